qam_tap_capture: RTL
====================

Name: qam_tap_capture

Overview:
- Parametrised, triggered capture buffer for the QAM demodulator debug and data-export path.
- Takes NUM_TAPS I/Q sample streams, such as the demult, defilter and demod stage outputs, and selects one at arm time.
- Stores up to DEPTH samples, optionally decimated, starting at a trigger.
- Replays the stored samples on a valid/ready stream, with a last flag, for offline constellation and filter analysis.

Parameters:
NUM_TAPS, 4, number of selectable I/Q tap streams
TAP_WIDTH, 16, signed width of each I and Q sample
DEPTH, 1024, capture memory depth in samples (power of two)
DECIM_WIDTH, 8, width of decimation factor field

Ports:
axi_clk  in  1  clock
axi_rstn  in  1  reset, asynchronous, active-low
tap_valid  in  NUM_TAPS  per-tap sample valid
tap_i  in  NUM_TAPS*TAP_WIDTH  packed I samples, tap k at [k*TAP_WIDTH +: TAP_WIDTH]
tap_q  in  NUM_TAPS*TAP_WIDTH  packed Q samples, same packing
cfg_sel  in  $clog2(NUM_TAPS)  tap select, sampled on arm
cfg_len  in  $clog2(DEPTH)+1  samples to capture, sampled on arm; 0 or >DEPTH means DEPTH
cfg_decim  in  DECIM_WIDTH  keep 1 of every N valid samples, sampled on arm; 0 and 1 mean keep all
cfg_trig_en  in  1  1 = wait for trig, 0 = start capture the cycle after arm
arm  in  1  single-cycle start request
abort  in  1  return to IDLE from any state
trig  in  1  level trigger
out_valid  out  1  readout sample valid
out_ready  in  1  readout accept
out_data  out  2*TAP_WIDTH  {q, i} of the sample
out_last  out  1  marks the final captured sample
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when capture completes
cap_count  out  $clog2(DEPTH)+1  samples written so far

Behaviour:
- Reset is asynchronous on axi_rstn low. It clears the state to IDLE, all counters, out_valid, out_last, out_data (0), busy, done and cap_count. Memory contents are not reset.
- States:
  - IDLE: arm latches cfg_* and moves to ARMED (cfg_trig_en=1) or CAPTURE (cfg_trig_en=0). cap_count clears on arm.
  - ARMED: the first cycle with trig=1 moves to CAPTURE. trig in the same cycle as arm is not seen.
  - CAPTURE: the decimation counter resets to 0 on entry. Each cycle with tap_valid[sel]=1:
    - if decim_cnt==0, write {q,i} at wr_ptr, then increment wr_ptr and cap_count;
    - decim_cnt increments and wraps at N-1.
    - Samples with tap_valid[sel]=0 are ignored and do not advance decim_cnt.
    - The write of sample len-1 moves to DRAIN on the next edge; done pulses in that first DRAIN cycle.
  - DRAIN: reads rd_ptr 0..len-1 through a synchronous-read RAM (1-cycle latency) into an output register. out_valid rises no earlier than 2 cycles after the last write.
    - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
    - Transfer occurs when out_valid && out_ready. A prefetch/skid register sustains 1 sample/cycle with out_ready held high.
    - out_last=1 only on sample len-1. After its transfer: IDLE, out_valid=0.
- Entry into CAPTURE on a trig cycle: the tap sample present in that same cycle, if valid, is sample 0.
- arm while busy is ignored. trig outside ARMED is ignored. cfg_* changes after arm have no effect.
- abort has priority over all other inputs in its cycle:
  - next state IDLE, out_valid=0, done not pulsed;
  - cap_count holds the value reached.
- DEPTH boundary: wr_ptr never wraps; capture stops at exactly len samples.
- No input backpressure. Tap samples arriving in ARMED or DRAIN are dropped.

Test Plan:
- Immediate capture: cfg_trig_en=0, sel=2, len=8, decim=1, tap 2 ramp i=k, q=-k, valid every cycle -> done 1 cycle after 8th write; readout with out_ready=1 gives 8 beats {-k,k}, k=0..7, out_last on beat 8, then busy=0.
- Trigger + decimation: sel=1, decim=3, len=4, trig asserted at ramp value 10 -> stored i = 10,13,16,19; cap_count=4.
- Gapped valid + backpressure: tap_valid 1-of-2 cycles, len=5; out_ready toggling 1,0,0,1 -> exactly 5 beats, data stable during stalls, no duplicates or drops.
- Full depth: len=0 (DEPTH=1024) -> 1024 samples stored, cap_count=1024, out_last on beat 1024.
- Abort: abort in ARMED -> IDLE next cycle, no done. Abort mid-DRAIN after 3 beats -> out_valid=0 next cycle. Re-arm works normally afterwards.
- Async reset mid-CAPTURE (axi_rstn low between clock edges) -> busy, out_valid, cap_count=0 immediately; arm after release behaves as fresh.

Source files
------------

// File: rtl/qam_tap_capture.sv
// Triggered capture buffer: records one selected I/Q tap stream (optionally decimated)
// into a DEPTH-entry RAM, then replays it on a valid/ready stream with a last flag.
module qam_tap_capture #(
   parameter int NUM_TAPS    = 4,
   parameter int TAP_WIDTH   = 16,
   parameter int DEPTH       = 1024,
   parameter int DECIM_WIDTH = 8
) (
   input  logic                          axi_clk,
   input  logic                          axi_rstn,
   input  logic [NUM_TAPS-1:0]           tap_valid,
   input  logic [NUM_TAPS*TAP_WIDTH-1:0] tap_i,
   input  logic [NUM_TAPS*TAP_WIDTH-1:0] tap_q,
   input  logic [$clog2(NUM_TAPS)-1:0]   cfg_sel,
   input  logic [$clog2(DEPTH):0]        cfg_len,
   input  logic [DECIM_WIDTH-1:0]        cfg_decim,
   input  logic                          cfg_trig_en,
   input  logic                          arm,
   input  logic                          abort,
   input  logic                          trig,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2*TAP_WIDTH-1:0]        out_data,
   output logic                          out_last,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(DEPTH):0]        cap_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int SW = $clog2(NUM_TAPS);
   localparam int DW = 2 * TAP_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

   state_t                 state, state_nxt;
   logic [SW-1:0]          sel_r;
   logic [LW-1:0]          len_r, len_eff;
   logic [DECIM_WIDTH-1:0] decim_r, decim_cnt, decim_nxt;
   logic [LW-1:0]          rd_ptr;
   logic                   rd_inflight, rd_inflight_last;
   logic                   skid_valid, skid_last;
   logic [DW-1:0]          skid_data, ram_q;
   logic [DW-1:0]          mem [DEPTH];

   logic                   sample_valid;
   logic [DW-1:0]          sample_data;
   logic                   capturing, wr_en, wr_last, rd_en, xfer, arm_go;
   logic [1:0]             occ, occ_after;

   // Readout stream: a beat transfers on any edge where out_valid && out_ready;
   // while out_valid=1 and out_ready=0, out_data and out_last are held unchanged.

   always_comb begin
      sample_valid = tap_valid[sel_r];
      sample_data  = {tap_q[int'(sel_r)*TAP_WIDTH +: TAP_WIDTH],
                      tap_i[int'(sel_r)*TAP_WIDTH +: TAP_WIDTH]};
      // A trigger cycle already counts as capture, so its sample becomes sample 0.
      capturing    = (state == S_CAPTURE) || ((state == S_ARMED) && trig);
      wr_en        = !abort && capturing && sample_valid && (decim_cnt == '0);
      wr_last      = wr_en && ((cap_count + LW'(1)) == len_r);
      xfer         = out_valid && out_ready;
      arm_go       = (state == S_IDLE) && arm && !abort;
      occ          = 2'(out_valid) + 2'(skid_valid) + 2'(rd_inflight);
      occ_after    = occ - 2'(xfer);
      // Two slots (output + skid) cover the one-cycle RAM latency at full rate.
      rd_en        = !abort && (state == S_DRAIN) && (rd_ptr != len_r) && (occ_after < 2'd2);

      if ((cfg_len == '0) || (cfg_len > LW'(DEPTH))) len_eff = LW'(DEPTH);
      else                                             len_eff = cfg_len;

      if ((decim_r <= DECIM_WIDTH'(1)) || (decim_cnt == decim_r - DECIM_WIDTH'(1)))
         decim_nxt = '0;
      else
         decim_nxt = decim_cnt + DECIM_WIDTH'(1);
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (arm) state_nxt = cfg_trig_en ? S_ARMED : S_CAPTURE;
            S_ARMED:   if (trig) state_nxt = wr_last ? S_DRAIN : S_CAPTURE;
            S_CAPTURE: if (wr_last) state_nxt = S_DRAIN;
            S_DRAIN:   if (xfer && out_last) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) state <= S_IDLE;
      else           state <= state_nxt;
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge axi_clk) begin
      if (wr_en) mem[cap_count[AW-1:0]] <= sample_data;
      if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         sel_r            <= '0;
         len_r            <= '0;
         decim_r          <= '0;
         decim_cnt        <= '0;
         cap_count        <= '0;
         rd_ptr           <= '0;
         rd_inflight      <= 1'b0;
         rd_inflight_last <= 1'b0;
         skid_valid       <= 1'b0;
         skid_last        <= 1'b0;
         skid_data        <= '0;
         out_valid        <= 1'b0;
         out_last         <= 1'b0;
         out_data         <= '0;
         done             <= 1'b0;
      end else begin
         done             <= wr_last;
         rd_inflight      <= rd_en;
         rd_inflight_last <= (rd_ptr == len_r - LW'(1));

         if (arm_go) begin
            sel_r     <= cfg_sel;
            len_r     <= len_eff;
            decim_r   <= cfg_decim;
            decim_cnt <= '0;
            cap_count <= '0;
            rd_ptr    <= '0;
         end
         if (!abort && capturing && sample_valid) decim_cnt <= decim_nxt;
         if (wr_en) cap_count <= cap_count + LW'(1);
         if (rd_en) rd_ptr <= rd_ptr + LW'(1);

         if (xfer || !out_valid) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_data   <= skid_data;
               out_last   <= skid_last;
               skid_valid <= rd_inflight;
               skid_data  <= ram_q;
               skid_last  <= rd_inflight_last;
            end else if (rd_inflight) begin
               out_valid <= 1'b1;
               out_data  <= ram_q;
               out_last  <= rd_inflight_last;
            end else begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         end else if (rd_inflight) begin
            skid_valid <= 1'b1;
            skid_data  <= ram_q;
            skid_last  <= rd_inflight_last;
         end

         if (abort) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            skid_valid  <= 1'b0;
            rd_inflight <= 1'b0;
         end
      end
   end

endmodule
